// File: rtl/scan_counter_pkg.sv
// Shared constants and the seven-segment glyph table for scan_counter.
package scan_counter_pkg;

  localparam logic [3:0] BCD_MAX   = 4'd9;
  localparam logic [3:0] HEX_MAX   = 4'hF;
  localparam logic       MODE_HEX  = 1'b0;
  localparam logic       MODE_BCD  = 1'b1;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low glyph, segment a at bit 0 through g at bit 6.
  function automatic logic [6:0] seg_glyph(input logic [3:0] digit);
    logic [6:0] seg;
    unique case (digit)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/scan_counter_digit.sv
// One 4-bit counter cell (hex or BCD) with carry/borrow in and out.
module scan_counter_digit
  import scan_counter_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       step_i,
  input  logic       up_i,
  input  logic       sel_i,
  input  logic       cin_i,
  output logic [3:0] next_o,
  output logic       cout_o
);

  logic [3:0] max_digit;

  // Next digit value and carry/borrow out; holds unless stepping with carry-in.
  always_comb begin
    next_o    = digit_i;
    cout_o    = 1'b0;
    max_digit = (sel_i == MODE_HEX) ? HEX_MAX : BCD_MAX;
    if (step_i && cin_i) begin
      if (up_i) begin
        // >= so that illegal BCD digits (A..F) also roll over to 0
        if (digit_i >= max_digit) begin
          next_o = 4'd0;
          cout_o = 1'b1;
        end else begin
          next_o = digit_i + 4'd1;
        end
      end else begin
        if (digit_i == 4'd0) begin
          next_o = max_digit;
          cout_o = 1'b1;
        end else if ((sel_i == MODE_BCD) && (digit_i > BCD_MAX)) begin
          next_o = BCD_MAX;
        end else begin
          next_o = digit_i - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/scan_counter.sv
// Multi-digit hex/BCD up/down counter with rate prescaler and 8-digit seven-segment scan driver.
// Define SCAN_COUNTER_BLANK_EN to blank leading zero digits (digit 0 is never blanked).
module scan_counter
  import scan_counter_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 100000,
  parameter int unsigned PRESC_W  = 32
) (
  input  logic                  scan_counter_port_clk,
  input  logic                  scan_counter_port_rst_n,
  input  logic                  scan_counter_port_clr,
  input  logic                  scan_counter_port_en,
  input  logic                  scan_counter_port_up,
  input  logic                  scan_counter_port_sel,
  input  logic [4:0]            scan_counter_port_factor,
  input  logic [DIGITS-1:0]     scan_counter_port_dp,
  output logic [4*DIGITS-1:0]   scan_counter_port_value,
  output logic                  scan_counter_port_wrap,
  output logic [6:0]            scan_counter_port_seg,
  output logic                  scan_counter_port_odp,
  output logic [7:0]            scan_counter_port_an
);

  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned TmrW = $clog2(SCAN_DIV);

  logic [PRESC_W-1:0]  presc_q, presc_mask;
  logic                tick, step;
  logic [4*DIGITS-1:0] value_q, value_d, value_next;
  logic [DIGITS:0]     carry;
  logic                wrap_q;
  logic [TmrW-1:0]     timer_q, timer_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [3:0]          cur_digit;
  logic                cur_dp, blank;
  logic [6:0]          seg_q, seg_d;
  logic                odp_q, odp_d;
  logic [7:0]          an_q, an_d;

  // Tick when the low 'factor' prescaler bits are all ones; factors past PRESC_W mask everything.
  always_comb begin
    presc_mask = '0;
    for (int i = 0; i < PRESC_W; i++) begin
      presc_mask[i] = (i < int'(scan_counter_port_factor));
    end
    tick = &(presc_q | ~presc_mask);
    step = tick & scan_counter_port_en & ~scan_counter_port_clr;
  end

  assign carry[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    scan_counter_digit u_digit (
      .digit_i (value_q[4*g +: 4]),
      .step_i  (step),
      .up_i    (scan_counter_port_up),
      .sel_i   (scan_counter_port_sel),
      .cin_i   (carry[g]),
      .next_o  (value_next[4*g +: 4]),
      .cout_o  (carry[g+1])
    );
  end

  // Clear wins over stepping; cells already hold their value when not stepping.
  always_comb begin
    value_d = scan_counter_port_clr ? '0 : value_next;
  end

  // Scan timer and digit index advance.
  always_comb begin
    timer_d = timer_q + TmrW'(1);
    idx_d   = idx_q;
    if (timer_q == TmrW'(SCAN_DIV - 1)) begin
      timer_d = '0;
      idx_d   = (idx_q == IdxW'(DIGITS - 1)) ? '0 : idx_q + IdxW'(1);
    end
  end

`ifdef SCAN_COUNTER_BLANK_EN
  logic [DIGITS-1:0] lead_zero;
  logic              zero_above;

  // lead_zero[i]: digit i and every higher digit are zero.
  always_comb begin
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above   = zero_above & (value_q[4*i +: 4] == 4'd0);
      lead_zero[i] = zero_above;
    end
  end
`endif

  // Select the live digit under the scan index and build the pin values.
  always_comb begin
    cur_digit = 4'd0;
    cur_dp    = 1'b0;
    blank     = 1'b0;
    an_d      = 8'hFF;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IdxW'(i)) begin
        cur_digit = value_q[4*i +: 4];
        cur_dp    = scan_counter_port_dp[i];
        an_d[i]   = 1'b0;
`ifdef SCAN_COUNTER_BLANK_EN
        blank     = (i > 0) && lead_zero[i];
`endif
      end
    end
    seg_d = blank ? SEG_BLANK : seg_glyph(cur_digit);
    odp_d = ~cur_dp;
  end

  // All state and registered outputs.
  always_ff @(posedge scan_counter_port_clk or negedge scan_counter_port_rst_n) begin
    if (!scan_counter_port_rst_n) begin
      presc_q <= '0;
      value_q <= '0;
      wrap_q  <= 1'b0;
      timer_q <= '0;
      idx_q   <= '0;
      seg_q   <= SEG_BLANK;
      odp_q   <= 1'b1;
      an_q    <= 8'hFF;
    end else begin
      presc_q <= presc_q + PRESC_W'(1);
      value_q <= value_d;
      wrap_q  <= carry[DIGITS];
      timer_q <= timer_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      odp_q   <= odp_d;
      an_q    <= an_d;
    end
  end

  assign scan_counter_port_value = value_q;
  assign scan_counter_port_wrap  = wrap_q;
  assign scan_counter_port_seg   = seg_q;
  assign scan_counter_port_odp   = odp_q;
  assign scan_counter_port_an    = an_q;

endmodule
